// File: rtl/ram8_clr_bank.sv
// ram8_clr_bank: eight-entry WIDTH-bit register bank with a sequenced bulk-clear engine.
// Latency: combinational read; writes visible the cycle after the write edge
//          (same cycle when RAM8_BYPASS_EN is defined and the bank is idle).
// Backpressure: none; loads that arrive during a clear sweep are discarded and flagged.
//
// Optional feature macro: RAM8_BYPASS_EN (write-through forwarding of in to out while idle).
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (clears all entries, aborts any sweep)
//   in           write data
//   address      entry select for read and write
//   load         write entry[address] <= in at the next rising edge (idle only)
//   clear_req    start a bulk clear of all eight entries (ignored while busy)
//   out          entry[address], combinational
//   busy         high while the clear sweep runs (exactly 8 cycles)
//   load_dropped one-cycle pulse following an edge whose load was refused
module ram8_clr_bank #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       address,
  input  logic             load,
  input  logic             clear_req,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             load_dropped
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             drop_q, drop_d;
  logic [WIDTH-1:0] mem_q [8];
  logic [WIDTH-1:0] mem_d [8];

  // Next-state, storage update and drop flag.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = 1'b0;
    mem_d   = mem_q;

    unique case (state_q)
      IDLE: begin
        // A same-edge load is still performed; the sweep overwrites it later.
        if (load) begin
          mem_d[address] = in;
        end
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = 3'd0;
        end
      end
      CLEAR: begin
        // Sweep order is fixed 0..7 regardless of address; clear_req is ignored.
        mem_d[cnt_q] = CLEAR_VAL;
        cnt_d        = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = IDLE;
        end
        if (load) begin
          drop_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      drop_q  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      mem_q   <= mem_d;
    end
  end

  // busy is exactly the registered CLEAR state: it rises on the entry edge
  // and falls on the edge that writes entry 7.
  assign busy         = (state_q == CLEAR);
  assign load_dropped = drop_q;

`ifdef RAM8_BYPASS_EN
  // Forward write data only while idle; loads during a sweep are refused.
  assign out = ((state_q == IDLE) && load) ? in : mem_q[address];
`else
  assign out = mem_q[address];
`endif

endmodule

// File: tb/tb_ram8_clr_bank.sv
module tb_ram8_clr_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] din;
  logic [2:0]  address;
  logic        load;
  logic        clear_req;
  logic [15:0] dout;
  logic        busy;
  logic        load_dropped;

  int nchk = 0;
  int nerr = 0;

`ifdef RAM8_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  ram8_clr_bank #(.WIDTH(16), .CLEAR_VAL(16'h0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in           (din),
    .address      (address),
    .load         (load),
    .clear_req    (clear_req),
    .out          (dout),
    .busy         (busy),
    .load_dropped (load_dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        load;
    logic [2:0]  addr;
    logic [15:0] din;
    logic [15:0] exp_out;   // stored value of entry[addr] before the edge
    logic        exp_busy;
    logic        exp_drop;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", nerr + 1, nchk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    logic [15:0] e;

    rst_n = 1'b0; din = '0; address = '0; load = 1'b0; clear_req = 1'b0;

    // Reset state: every address reads zero, flags low.
    #12;
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      chk($sformatf("reset_out_a%0d", a), 32'(dout), 32'h0);
    end
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_drop", 32'(load_dropped), 32'h0);
    rst_n = 1'b1;
    tick();

    // Table: writes, read-back, then fill entries with 1111..8888.
    vt[0] = '{1'b1, 3'd3, 16'hA5A5, 16'h0000, 1'b0, 1'b0};
    vt[1] = '{1'b1, 3'd7, 16'h1234, 16'h0000, 1'b0, 1'b0};
    vt[2] = '{1'b0, 3'd3, 16'h0000, 16'hA5A5, 1'b0, 1'b0};
    vt[3] = '{1'b0, 3'd7, 16'h0000, 16'h1234, 1'b0, 1'b0};
    vt[4] = '{1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      e = (i == 3) ? 16'hA5A5 : (i == 7) ? 16'h1234 : 16'h0000;
      vt[5 + i] = '{1'b1, 3'(i), 16'(16'h1111 * (i + 1)), e, 1'b0, 1'b0};
    end
    vt[13] = '{1'b0, 3'd5, 16'h0000, 16'h6666, 1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      load = vt[i].load; address = vt[i].addr; din = vt[i].din;
      #1;
      e = (BYP && vt[i].load && !vt[i].exp_busy) ? vt[i].din : vt[i].exp_out;
      chk($sformatf("vec%0d_out", i), 32'(dout), 32'(e));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].exp_busy));
      chk($sformatf("vec%0d_drop", i), 32'(load_dropped), 32'(vt[i].exp_drop));
      tick();
    end
    load = 1'b0; din = '0;

    // Clear sweep: entry 5 keeps 6666 until the 6th clear edge.
    address = 3'd5; clear_req = 1'b1;
    #1;
    chk("clr_start_busy", 32'(busy), 32'h0);
    tick();
    clear_req = 1'b0;
    nb = 0;
    for (int k = 0; k < 20 && busy; k++) begin
      chk($sformatf("clr_a5_k%0d", k), 32'(dout), (nb < 6) ? 32'h6666 : 32'h0);
      nb++;
      tick();
    end
    chk("clr_busy_cycles", 32'(nb), 32'd8);
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      chk($sformatf("clr_after_a%0d", a), 32'(dout), 32'h0);
    end

    // Load + second clear_req mid-sweep: dropped, no extension.
    address = 3'd2; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    nb = 0;
    for (int k = 0; k < 20 && busy; k++) begin
      if (k == 4) begin
        load = 1'b1; address = 3'd2; din = 16'hBEEF; clear_req = 1'b1;
      end
      #1;
      if (k == 4) chk("drop_nofwd_out", 32'(dout), 32'h0);
      chk($sformatf("drop_flag_k%0d", k), 32'(load_dropped), (k == 5) ? 32'h1 : 32'h0);
      nb++;
      tick();
      load = 1'b0; clear_req = 1'b0; din = '0;
    end
    chk("drop_busy_cycles", 32'(nb), 32'd8);
    chk("drop_after_flag", 32'(load_dropped), 32'h0);
    address = 3'd2;
    #1;
    chk("drop_entry2", 32'(dout), 32'h0);

    // Same-edge load and clear_req from IDLE.
    address = 3'd4; din = 16'hCAFE; load = 1'b1; clear_req = 1'b1;
    #1;
    chk("same_req_out", 32'(dout), BYP ? 32'hCAFE : 32'h0);
    tick();
    load = 1'b0; clear_req = 1'b0; din = '0;
    nb = 0;
    for (int k = 0; k < 20 && busy; k++) begin
      if (k == 0) chk("same_loaded_a4", 32'(dout), 32'hCAFE);
      chk($sformatf("same_drop_k%0d", k), 32'(load_dropped), 32'h0);
      nb++;
      tick();
    end
    chk("same_busy_cycles", 32'(nb), 32'd8);
    chk("same_entry4", 32'(dout), 32'h0);
    chk("same_drop_end", 32'(load_dropped), 32'h0);

    // Reset mid-sweep after the 4th clear edge.
    for (int a = 0; a < 8; a++) begin
      address = 3'(a); din = 16'hFFFF; load = 1'b1;
      tick();
    end
    load = 1'b0; din = '0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (4) tick();
    chk("rst_busy_before", 32'(busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy_now", 32'(busy), 32'h0);
    chk("rst_drop_now", 32'(load_dropped), 32'h0);
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      chk($sformatf("rst_mid_a%0d", a), 32'(dout), 32'h0);
    end
    rst_n = 1'b1;
    tick();
    address = 3'd6; din = 16'h0F0F; load = 1'b1;
    tick();
    load = 1'b0; din = '0;
    chk("post_rst_write", 32'(dout), 32'h0F0F);
    chk("post_rst_busy", 32'(busy), 32'h0);
    repeat (10) tick();
    chk("no_resume_busy", 32'(busy), 32'h0);
    chk("no_resume_a6", 32'(dout), 32'h0F0F);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
